// File: rtl/sd_event_packer.sv
// sd_event_packer: round-robin arbiter over NUM_CH detector channels. It packs each
// accepted sample into a timestamped header word and a data word for the SD write FIFO.
module sd_event_packer #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int TS_W   = 32
) (
    input  logic                     clk210_p,
    input  logic                     reset_n_p,
    input  logic                     enable_p,
    input  logic [NUM_CH-1:0]        ch_valid_p,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_p,
    output logic [NUM_CH-1:0]        ch_ready_p,
    input  logic [TS_W-1:0]          timekeeper_time_p,
    input  logic                     timekeeper_ready_p,
    output logic [31:0]              sd_write_fifo_din_p,
    output logic                     sd_write_fifo_wr_en_p,
    input  logic                     sd_write_fifo_full_p,
    output logic [15:0]              drop_count_p,
    output logic                     busy_p
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0]        LAST_CH = 4'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_CH  = NUM_CH'(1'b1);

    state_t            state_q, state_d;
    logic [3:0]        last_grant_q, last_grant_d;
    logic [3:0]        grant_q, grant_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [23:0]       ts_q, ts_d;
    logic [15:0]       drop_count_q, drop_count_d;
    // run_q keeps ch_ready_p quiet until the first rising edge after reset release.
    logic              run_q, run_d;

    logic              found_s;
    logic [3:0]        pick_s;
    logic              accept_s;
    logic [23:0]       sample_ext_s;
    logic              ts_unused_s;

    assign ts_unused_s = ^timekeeper_time_p;

    // Round-robin search starting one past the last granted channel, with wrap.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        pick_s  = 4'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!found_s && ch_valid_p[idx]) begin
                found_s = 1'b1;
                pick_s  = 4'(idx);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Next-state, capture registers and FIFO-side outputs.
    always_comb begin
        state_d               = state_q;
        last_grant_d          = last_grant_q;
        grant_d               = grant_q;
        sample_d              = sample_q;
        ts_d                  = ts_q;
        drop_count_d          = drop_count_q;
        run_d                 = 1'b1;
        accept_s              = 1'b0;
        ch_ready_p            = '0;
        sd_write_fifo_wr_en_p = 1'b0;
        sd_write_fifo_din_p   = 32'd0;
        sample_ext_s          = 24'd0;
        sample_ext_s[DATA_W-1:0] = sample_q;
        case (state_q)
            ST_IDLE: begin
                accept_s = run_q && enable_p && found_s;
                if (accept_s) begin
                    ch_ready_p   = ONE_CH << pick_s;
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    sample_d     = ch_data_p[int'(pick_s)*DATA_W +: DATA_W];
                    ts_d         = timekeeper_time_p[23:0];
                    if (timekeeper_ready_p) begin
                        state_d = ST_HDR;
                    end else if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end else begin
                        drop_count_d = drop_count_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                sd_write_fifo_wr_en_p = !sd_write_fifo_full_p;
                sd_write_fifo_din_p   = {4'hA, grant_q, ts_q};
                if (!sd_write_fifo_full_p) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                sd_write_fifo_wr_en_p = !sd_write_fifo_full_p;
                sd_write_fifo_din_p   = {4'h5, 4'h0, sample_ext_s};
                if (!sd_write_fifo_full_p) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any in-flight record.
    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_CH;
            grant_q      <= 4'd0;
            sample_q     <= '0;
            ts_q         <= 24'd0;
            drop_count_q <= 16'd0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            sample_q     <= sample_d;
            ts_q         <= ts_d;
            drop_count_q <= drop_count_d;
            run_q        <= run_d;
        end
    end

    assign drop_count_p = drop_count_q;
    assign busy_p       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_event_packer.sv
// Bench for sd_event_packer: directed scenarios plus randomized traffic, all checked
// against a queue-based record model (pending FIFO words, round-robin pointer, drop count).
module tb_sd_event_packer;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NCH-1:0]    valid;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    ready;
    logic [31:0]       tk_time;
    logic              tk_ready;
    logic [31:0]       din;
    logic              wr_en;
    logic              full;
    logic [15:0]       drops;
    logic              busy;

    logic              valid2;
    logic [23:0]       data2;
    logic              ready2;
    logic [31:0]       din2;
    logic              wr_en2;
    logic              full2;
    logic [15:0]       drops2;
    logic              busy2;

    always #5 clk = ~clk;

    sd_event_packer #(.NUM_CH(NCH), .DATA_W(DW), .TS_W(32)) dut (
        .clk210_p(clk), .reset_n_p(rst_n), .enable_p(enable),
        .ch_valid_p(valid), .ch_data_p(data), .ch_ready_p(ready),
        .timekeeper_time_p(tk_time), .timekeeper_ready_p(tk_ready),
        .sd_write_fifo_din_p(din), .sd_write_fifo_wr_en_p(wr_en),
        .sd_write_fifo_full_p(full), .drop_count_p(drops), .busy_p(busy)
    );

    sd_event_packer #(.NUM_CH(1), .DATA_W(24), .TS_W(24)) dut2 (
        .clk210_p(clk), .reset_n_p(rst_n), .enable_p(enable),
        .ch_valid_p(valid2), .ch_data_p(data2), .ch_ready_p(ready2),
        .timekeeper_time_p(tk_time[23:0]), .timekeeper_ready_p(tk_ready),
        .sd_write_fifo_din_p(din2), .sd_write_fifo_wr_en_p(wr_en2),
        .sd_write_fifo_full_p(full2), .drop_count_p(drops2), .busy_p(busy2)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wlog[$];
    logic [31:0] wlog2[$];
    int          m_last;
    int          m_drop;
    bit          m_live;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] v, input int last);
        int c;
        for (int k = 0; k < NCH; k++) begin
            c = (last + 1 + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_last = NCH - 1;
        m_drop = 0;
        m_live = 1'b0;
    endtask

    // One clock: inputs already set at the negedge; check, advance model, return at next negedge.
    task automatic step();
        int g;
        logic [NCH-1:0] exp_ready;
        #1;
        g = (m_live && enable && exp_q.size() == 0) ? rr_pick(valid, m_last) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("ch_ready", 32'(ready), 32'(exp_ready));
        check_eq("wr_en", 32'(wr_en), 32'((exp_q.size() != 0) && !full));
        check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
        check_eq("drop_count", 32'(drops), 32'(m_drop));
        if (exp_q.size() != 0) check_eq("din", din, exp_q[0]);
        if (wr_en) wlog.push_back(din);
        if (wr_en2) wlog2.push_back(din2);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0) begin
                if (!full) void'(exp_q.pop_front());
            end else if (g >= 0) begin
                m_last = g;
                if (tk_ready) begin
                    exp_q.push_back({4'hA, 4'(g), tk_time[23:0]});
                    exp_q.push_back({8'h50, 8'h00, data[g*DW +: DW]});
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            m_live = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        valid2 = 1'b0;
        full = 1'b0;
        tk_ready = 1'b1;
        enable = 1'b1;
        model_reset();
        wlog.delete();
        wlog2.delete();
        #1;
        check_eq("rst_din", din, 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; valid = '0; data = '0; tk_time = 32'd0;
        tk_ready = 1'b0; full = 1'b0; valid2 = 1'b0; data2 = 24'd0; full2 = 1'b0;
        model_reset();
        @(negedge clk);

        // Single record on channel 2.
        do_reset();
        valid = 4'b0100; data[2*DW +: DW] = 16'h1234; tk_time = 32'h00ABCDEF;
        step();
        valid = '0;
        step();
        step();
        check_eq("single_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check_eq("single_hdr", wlog[0], 32'hA2ABCDEF);
            check_eq("single_data", wlog[1], 32'h50001234);
        end

        // Fairness: all channels pending, 24 cycles give 8 records.
        do_reset();
        valid = 4'b1111;
        for (int i = 0; i < 24; i++) begin
            data = {$urandom, $urandom};
            tk_time = $urandom;
            step();
        end
        check_eq("fair_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 8 && 2 * i < wlog.size(); i++)
            check_eq("fair_chan", 32'(wlog[2*i][27:24]), 32'(i % 4));
        valid = '0;
        step(); step(); step();

        // Backpressure during the header.
        do_reset();
        valid = 4'b0001; data[DW-1:0] = 16'hBEEF; tk_time = 32'h77112233;
        step();
        valid = '0; full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_din_held", din, 32'hA0112233);
            check_eq("bp_no_write", 32'(wr_en), 32'd0);
            step();
        end
        full = 1'b0;
        step();
        step();
        check_eq("bp_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check_eq("bp_hdr", wlog[0], 32'hA0112233);
            check_eq("bp_data", wlog[1], 32'h5000BEEF);
        end

        // Drops while the timekeeper is not ready, then saturation.
        do_reset();
        tk_ready = 1'b0; valid = 4'b0010;
        step(); step(); step();
        valid = '0;
        step();
        check_eq("drop_three", 32'(drops), 32'd3);
        check_eq("drop_no_write", 32'(wlog.size()), 32'd0);
        force dut.drop_count_q = 16'hFFFF;
        m_drop = 65535;
        step();
        release dut.drop_count_q;
        valid = 4'b0010;
        step();
        valid = '0;
        step();
        check_eq("drop_saturate", 32'(drops), 32'h0000FFFF);

        // Reset asserted during the data phase.
        do_reset();
        valid = 4'b0010; tk_ready = 1'b1;
        step();
        valid = '0;
        step();
        check_eq("mid_in_data", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_wr_en", 32'(wr_en), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        valid = 4'b1111;
        step();
        #1;
        check_eq("mid_first_grant", 32'(ready), 32'h1);
        check_eq("mid_drop", 32'(drops), 32'd0);
        step();
        valid = '0;
        step(); step(); step();

        // One-channel, 24-bit instance.
        do_reset();
        valid2 = 1'b1; data2 = 24'hC3A5F0; tk_time = 32'h12345678;
        #1;
        check_eq("p1_ready", 32'(ready2), 32'd1);
        step();
        valid2 = 1'b0;
        step();
        step();
        check_eq("p1_count", 32'(wlog2.size()), 32'd2);
        if (wlog2.size() == 2) begin
            check_eq("p1_hdr", wlog2[0], 32'hA0345678);
            check_eq("p1_data", wlog2[1], 32'h50C3A5F0);
        end
        check_eq("p1_idle", 32'(busy2), 32'd0);
        check_eq("p1_drops", 32'(drops2), 32'd0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            valid    = NCH'($urandom);
            data     = {$urandom, $urandom};
            tk_time  = $urandom;
            tk_ready = ($urandom_range(0, 9) != 0);
            full     = ($urandom_range(0, 3) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sd_event_packer.md
SD_EVENT_PACKER -- requirements
Module: sd_event_packer

Interface
REQ-001 Parameter NUM_CH, default 4, number of detector channels, legal range 1..16.
REQ-002 Parameter DATA_W, default 16, sample width per channel, legal range 1..24.
REQ-003 Parameter TS_W, default 32, timekeeper width, legal range 24..32.
REQ-004 clk210_p  input  1  sole clock, all logic rising-edge.
REQ-005 reset_n_p  input  1  asynchronous active-low reset.
REQ-006 enable_p  input  1  when low, no new channel accepted; an in-flight record completes.
REQ-007 ch_valid_p  input  NUM_CH  per-channel sample-pending flag.
REQ-008 ch_data_p  input  NUM_CH*DATA_W  channel i sample at bits [i*DATA_W +: DATA_W].
REQ-009 ch_ready_p  output  NUM_CH  one-hot accept strobe; a sample transfers when valid and ready are both high.
REQ-010 timekeeper_time_p  input  TS_W  free-running timestamp.
REQ-011 timekeeper_ready_p  input  1  timestamp valid.
REQ-012 sd_write_fifo_din_p  output  32  word to SD write FIFO.
REQ-013 sd_write_fifo_wr_en_p  output  1  FIFO write strobe.
REQ-014 sd_write_fifo_full_p  input  1  FIFO full.
REQ-015 drop_count_p  output  16  samples discarded because the timestamp was not ready.
REQ-016 busy_p  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, HDR, DATA.
REQ-018 IDLE: if enable_p=1 and any ch_valid_p bit is set, grant exactly one channel by round-robin, searching from (last_grant+1) mod NUM_CH upward with wrap.
REQ-019 The grant asserts ch_ready_p[g] for exactly one cycle, combinationally in IDLE, and never while in HDR or DATA.
REQ-020 On accept: latch the sample, g and timekeeper_time_p[23:0]; set last_grant to g.
REQ-021 On accept with timekeeper_ready_p=1, go to HDR.
REQ-022 On accept with timekeeper_ready_p=0: drop the sample, stay in IDLE, increment drop_count_p, saturating at 16'hFFFF.
REQ-023 HDR: sd_write_fifo_wr_en_p = !sd_write_fifo_full_p; din = {4'hA, g[3:0], ts[23:0]}; advance to DATA only on a write.
REQ-024 DATA: wr_en = !full; din = {4'h5, 4'h0, sample zero-extended to 24 bits}; advance to IDLE only on a write.
REQ-025 wr_en and din are combinational from state, latched registers and full; wr_en is never high in IDLE.
REQ-026 While full=1, the FSM holds its state and din is stable; no word is lost or duplicated.
REQ-027 Latency: accept at cycle N gives header write at N+1 and data write at N+2 when not full; maximum throughput is 1 record per 3 cycles.
REQ-028 Header and data words of one record are always written consecutively; no other record's words are interleaved.
REQ-029 ch_valid_p deasserting while in HDR or DATA has no effect on the in-flight record.

Reset
REQ-030 reset_n_p low asynchronously forces: state=IDLE, last_grant=NUM_CH-1 (so channel 0 has first priority), drop_count_p=0, ch_ready_p=0, wr_en=0, din=0, busy_p=0.
REQ-031 Reset asserted mid-record abandons the record; no further write occurs.
REQ-032 Outputs take their reset values immediately on assertion and remain there until the first rising edge after deassertion.

Verification
REQ-033 Single: ch_valid=4'b0100, data[2]=16'h1234, time=32'h00ABCDEF, tk_ready=1 -> ch_ready=4'b0100 for 1 cycle; writes 32'hA2ABCDEF then 32'h50001234 on consecutive cycles.
REQ-034 Fairness: all 4 channels valid continuously from reset -> grant order 0,1,2,3,0,...; 8 records produce 16 writes in 24 cycles.
REQ-035 Backpressure: full=1 for 5 cycles during HDR -> wr_en=0 and din held; the header is written on the first cycle with full=0, followed by the data word.
REQ-036 Drop: tk_ready=0 with channel 1 valid for 3 accepts -> drop_count=3, no FIFO writes; with the counter preloaded to 16'hFFFF, one more drop keeps it at 16'hFFFF.
REQ-037 Reset mid-record: reset_n low during DATA -> wr_en=0 at once; after release, drop_count=0, state IDLE, channel 0 granted first.
REQ-038 Parameter sweep: NUM_CH=1 and DATA_W=24 -> header channel field=0 and data bits [23:0] pass unmodified.
